// File: rtl/fp_normalize_seq.sv
// Multi-cycle post-addition normaliser for the small floating-point adder.
// Accepts a raw sum {carry, leading, fraction} plus a provisional exponent.
// It corrects a carry with one right shift, or walks the fraction left one
// bit per cycle until the leading bit is set. The exponent tracks each shift.
// Overflow saturates the exponent to all-ones. Underflow stops at exponent 0.
module fp_normalize_seq #(
  parameter int EXP_W  = 3,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [FRAC_W+1:0] in_frac,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  out_exp,
  output logic [FRAC_W:0]   out_frac,
  output logic              overflow,
  output logic              underflow,
  output logic              zero
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [EXP_W:0]   EXP_MAX_WIDE = {1'b0, EXP_MAX};
  localparam logic [EXP_W:0]   EXP_ONE_WIDE = {{EXP_W{1'b0}}, 1'b1};

  state_t            state;
  state_t            state_nx;
  logic              armed;
  logic [EXP_W-1:0]  exp_q;
  logic [FRAC_W:0]   frac_q;
  logic              overflow_q;
  logic              underflow_q;
  logic              zero_q;

  logic              accept;
  logic              release_out;
  logic              carry;
  logic              lead;
  logic [EXP_W:0]    exp_inc;
  logic              acc_done;

  assign accept      = in_valid & in_ready;
  assign release_out = out_valid & out_ready;
  assign carry       = in_frac[FRAC_W+1];
  assign lead        = in_frac[FRAC_W];
  assign exp_inc     = {1'b0, in_exp} + EXP_ONE_WIDE;
  assign acc_done    = (in_frac == '0) | (in_exp == EXP_MAX) | carry | lead;

  // State register; reset abandons any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Holds in_ready low during reset and until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // Next-state selection: words needing no left shift go straight to DONE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = acc_done ? DONE : SHIFT;
      SHIFT:   if (frac_q[FRAC_W] || (exp_q == '0)) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs come from the state alone; there is no overlap between words.
  always_comb begin
    in_ready  = (state == IDLE) & armed;
    out_valid = (state == DONE);
  end

  // Datapath. It loads and classifies the word, then shifts it left one bit
  // per cycle. Flags clear on the output handshake. Exponent and fraction
  // keep their values until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q       <= '0;
      frac_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            zero_q      <= 1'b0;
            if (in_frac == '0) begin
              zero_q <= 1'b1;
              exp_q  <= '0;
              frac_q <= '0;
            end else if (in_exp == EXP_MAX) begin
              overflow_q <= 1'b1;
              exp_q      <= EXP_MAX;
              frac_q     <= '0;
            end else if (carry) begin
              if (exp_inc >= EXP_MAX_WIDE) begin
                overflow_q <= 1'b1;
                exp_q      <= EXP_MAX;
                frac_q     <= '0;
              end else begin
                exp_q  <= exp_inc[EXP_W-1:0];
                frac_q <= in_frac[FRAC_W+1:1];
              end
            end else begin
              exp_q  <= in_exp;
              frac_q <= in_frac[FRAC_W:0];
            end
          end
        end
        SHIFT: begin
          if (!frac_q[FRAC_W]) begin
            if (exp_q == '0) begin
              underflow_q <= 1'b1;
            end else begin
              frac_q <= {frac_q[FRAC_W-1:0], 1'b0};
              exp_q  <= exp_q - EXP_ONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            zero_q      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_exp   = exp_q;
  assign out_frac  = frac_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign zero      = zero_q;

endmodule

// File: doc/fp_normalize_seq.md
Name: fp_normalize_seq

Overview:
Parametrised, multi-cycle post-addition normaliser for the small floating-point adder datapath. It takes the raw sum {carry, leading bit, fraction} and a provisional exponent. It then shifts left one bit per cycle, or right once on carry, until the leading bit is 1, adjusting the exponent to match. It flags overflow, underflow and zero. Input and output each use a valid/ready handshake, so it sits between the fraction adder and the result register.

Parameters:
EXP_W, 3, exponent width (unsigned, biased); all-ones is reserved as overflow/infinity
FRAC_W, 4, stored fraction width excluding the leading bit

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input word valid
in_ready  out  1  block can accept a word
in_exp  in  EXP_W  provisional exponent
in_frac  in  FRAC_W+2  {carry, leading bit, fraction}
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_exp  out  EXP_W  normalised exponent
out_frac  out  FRAC_W+1  {leading bit, fraction}
overflow  out  1  exponent saturated to all-ones
underflow  out  1  exponent reached 0 before normalisation completed
zero  out  1  input fraction was all zeros

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - Reset forces state IDLE.
  - out_valid, out_exp, out_frac, overflow, underflow and zero all go to 0.
  - in_ready is 0 while rst_n is low and 1 from the first clk edge after release.
  - Reset mid-operation discards the word in flight; no partial result is ever presented.
- States: IDLE, SHIFT, DONE. in_ready = (state == IDLE) only; there is no overlap between words.
- Acceptance (IDLE, in_valid & in_ready): at that edge, capture exp/frac and evaluate in priority order:
  1. frac == 0: go to DONE with zero=1, out_exp=0, out_frac=0.
  2. in_exp == all-ones: go to DONE with overflow=1, out_exp=all-ones, out_frac=0.
  3. carry = 1:
     - If in_exp + 1 >= all-ones: overflow, out_exp=all-ones, out_frac=0.
     - Otherwise: out_frac = in_frac[FRAC_W+1:1] (right shift, LSB truncated), out_exp = in_exp + 1. Go to DONE.
  4. Leading bit = 1: go to DONE with values unchanged.
  5. Otherwise: go to SHIFT.
- SHIFT, evaluated each cycle:
  - If frac[FRAC_W] == 1: go to DONE.
  - Else if exp == 0: go to DONE with underflow=1; frac is left unshifted (denormal).
  - Else: frac <<= 1 (zero fill), exp -= 1; the leading-bit check is repeated next cycle.
- Latency, in edges from the acceptance edge to out_valid high:
  - 1 for zero, overflow, carry and already-normal cases.
  - 1 + n + 1 for n left shifts (the final detection cycle counts).
  - Maximum is FRAC_W + 2.
- DONE:
  - out_valid = 1; all outputs held stable while out_ready = 0.
  - On out_valid & out_ready: go to IDLE and clear out_valid and the flags at that edge.
  - out_exp and out_frac hold their value until the next load.
- Flags are mutually exclusive and valid only while out_valid = 1.
- All exponent arithmetic is unsigned EXP_W bits; wrap is never visible (saturate or underflow as above).

Test Plan:
1. Already normal: EXP_W=3, FRAC_W=4, in_exp=3, in_frac=6'b01_0110 → out_valid 1 edge after accept, out_frac=5'b10110, out_exp=3, no flags.
2. Carry: in_exp=3, in_frac=6'b10_0101 → 1 edge, out_frac=5'b10010, out_exp=4, no flags.
3. Four shifts: in_exp=5, in_frac=6'b00_0001 → out_valid 6 edges after accept, out_frac=5'b10000, out_exp=1, no flags.
4. Underflow: in_exp=2, in_frac=6'b00_0001 → 4 edges, out_frac=5'b00100, out_exp=0, underflow=1. Also: in_exp=6, in_frac=6'b11_0000 → overflow=1, out_exp=7, out_frac=0.
5. Zero and back-pressure: in_frac=0, in_exp=5 → zero=1, out_exp=0. Hold out_ready=0 for 5 cycles → outputs stable, in_ready=0. After the out_ready handshake, in_ready=1 next cycle.
6. Reset mid-SHIFT: drop rst_n during case 3 → out_valid=0 immediately. in_ready=1 after release. A new word then normalises correctly.
